// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and occupancy-width helper for pipe_chain_cg
package pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;

    // Enough bits to count 0..depth valid stages inclusive
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/clock_gating_cell.sv
// rtl/clock_gating_cell.sv - latch-based integrated clock gate with scan override
module clock_gating_cell (
    input  logic i_clk,
    input  logic i_en,
    input  logic i_scan_en,
    output logic o_gclk
);

    logic r_en_lat;

    // Enable is captured while the clock is low so gclk cannot glitch in the high phase
    always_latch begin
        if (!i_clk) r_en_lat <= i_en | i_scan_en;
    end

    assign o_gclk = i_clk & r_en_lat;

endmodule

// File: rtl/pipe_stage_cg.sv
// rtl/pipe_stage_cg.sv - one valid/ready register stage; PIPE_CHAIN_CG_EN selects gated data clock
module pipe_stage_cg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             i_flush,
    input  logic             i_cap,
    input  logic             i_rdy,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH:0]   o_stage
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid sets on capture, clears when our beat leaves with nothing behind it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_valid <= 1'b0;
        else if (i_flush) r_valid <= 1'b0;
        else              r_valid <= i_cap | (r_valid & !i_rdy);
    end

`ifdef PIPE_CHAIN_CG_EN
    logic w_gclk;

    clock_gating_cell u_icg (
        .i_clk     (clk),
        .i_en      (i_cap),
        .i_scan_en (scan_en),
        .o_gclk    (w_gclk)
    );

    // Data flop sees a clock only on capture cycles; the enable keeps scan-forced clocks harmless
    always_ff @(posedge w_gclk or posedge rst) begin
        if (rst)        r_data <= '0;
        else if (i_cap) r_data <= i_data;
    end
`else
    logic w_unused_scan;
    assign w_unused_scan = scan_en;

    // Data flop on the free-running clock with a load enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_data <= '0;
        else if (i_cap) r_data <= i_data;
    end
`endif

    assign o_stage = {r_valid, r_data};

endmodule

// File: rtl/pipe_chain_cg.sv
// rtl/pipe_chain_cg.sv - DEPTH-stage flushable valid/ready register chain; PIPE_CHAIN_CG_EN enables ICGs
module pipe_chain_cg
    import pipe_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy,
    output logic             idle
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           w_stage [DEPTH];
    logic [WIDTH-1:0] w_din   [DEPTH];
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_cap;
    logic             w_down_rdy;
    logic             w_out_fire;
    logic [CNT_W-1:0] r_occ;

    // Ready ripples back from the output so bubbles collapse; captures follow from it
    always_comb begin
        w_rdy      = '0;
        w_cap      = '0;
        w_down_rdy = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i]   = !w_stage[i].valid | w_down_rdy;
            w_down_rdy = w_rdy[i];
        end
        in_ready = w_rdy[0] & !flush & !rst;
        w_cap[0] = in_valid & in_ready;
        for (int i = 1; i < DEPTH; i++) begin
            w_cap[i] = w_stage[i-1].valid & w_rdy[i];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_din[g] = in_data;
        end else begin : g_body
            assign w_din[g] = w_stage[g-1].data;
        end

        pipe_stage_cg #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .scan_en (scan_en),
            .i_flush (flush),
            .i_cap   (w_cap[g]),
            .i_rdy   (w_rdy[g]),
            .i_data  (w_din[g]),
            .o_stage (w_stage[g])
        );
    end

    assign out_valid  = w_stage[DEPTH-1].valid;
    assign out_data   = w_stage[DEPTH-1].data;
    assign w_out_fire = out_valid & out_ready;

    // Occupancy tracks accepts minus emits; simultaneous accept and emit cancel
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_occ <= '0;
        else if (flush)                   r_occ <= '0;
        else if (w_cap[0] && !w_out_fire) r_occ <= r_occ + CNT_W'(1);
        else if (!w_cap[0] && w_out_fire) r_occ <= r_occ - CNT_W'(1);
    end

    assign occupancy = r_occ;
    assign idle      = (r_occ == '0) & !in_valid;

endmodule

// File: tb/tb_pipe_chain_cg.sv
// tb/tb_pipe_chain_cg.sv - directed self-checking bench for pipe_chain_cg at DEPTH=3
module tb_pipe_chain_cg;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             scan_en;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic             idle;

    int errors = 0;
    int checks = 0;

    pipe_chain_cg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] drain_exp [3];
        int acc;
        int em;
        drain_exp = '{16'h00A2, 16'h00A3, 16'h00A4};

        rst = 1'b1; scan_en = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_occ",       32'(occupancy), 32'd0);
        chk("rst_idle",      32'(idle),      32'd1);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        in_valid = 1'b1;
        #1;
        chk("rst_idle_inv",  32'(idle),      32'd0);
        chk("rst_in_ready2", 32'(in_ready),  32'd0);
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("rel_in_ready",  32'(in_ready),  32'd1);

        // streaming 0x0001..0x0010 with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 16);
            in_data  = 16'(k + 1);
            #1;
            acc = (k < 16) ? k : 16;
            em  = (k > 3) ? k - 3 : 0;
            if (em > 16) em = 16;
            chk("stream_occ", 32'(occupancy), 32'(acc - em));
            chk("stream_out_valid", 32'(out_valid), 32'((k >= 3) && (k < 19)));
            if ((k >= 3) && (k < 19))
                chk("stream_out_data", 32'(out_data), 32'(k - 2));
            if (k < 16)
                chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick;
        end

        // fill with downstream stalled, scan clock override active
        out_ready = 1'b0;
        scan_en   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = (k < 3) ? 16'(16'h00A1 + k) : 16'h00A4;
            #1;
            chk("fill_in_ready", 32'(in_ready),  32'(k < 3));
            chk("fill_occ",      32'(occupancy), 32'((k < 3) ? k : 3));
            if (k >= 3) begin
                chk("fill_out_valid", 32'(out_valid), 32'd1);
                chk("fill_out_data",  32'(out_data),  32'h00A1);
            end
            tick;
        end

        // full chain: accept and emit in the same cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00A4;
        #1;
        chk("full_in_ready",  32'(in_ready), 32'd1);
        chk("full_out_data",  32'(out_data), 32'h00A1);
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drain_out_valid", 32'(out_valid), 32'd1);
            chk("drain_out_data",  32'(out_data),  32'(drain_exp[k]));
            chk("drain_occ",       32'(occupancy), 32'(3 - k));
            tick;
        end
        #1;
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        chk("drained_occ",       32'(occupancy), 32'd0);
        chk("drained_idle",      32'(idle),      32'd1);

        // flush with two beats in flight and 0xBEEF offered
        scan_en   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00B1;
        tick;
        in_data   = 16'h00B2;
        tick;
        in_data   = 16'hBEEF;
        flush     = 1'b1;
        #1;
        chk("flush_occ_before", 32'(occupancy), 32'd2);
        chk("flush_in_ready",   32'(in_ready),  32'd0);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_occ",       32'(occupancy), 32'd0);
        chk("flush_idle",      32'(idle),      32'd1);
        chk("flush_in_ready2", 32'(in_ready),  32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00C1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_flush_valid", 32'(out_valid), 32'(k == 2));
            if (k == 2)
                chk("post_flush_data", 32'(out_data), 32'h00C1);
            tick;
        end

        // reset asserted mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h00D1;
        tick;
        in_data   = 16'h00D2;
        tick;
        in_data   = 16'h00D3;
        tick;
        in_valid  = 1'b0;
        #1;
        chk("prerst_out_valid", 32'(out_valid), 32'd1);
        chk("prerst_out_data",  32'(out_data),  32'h00D1);
        chk("prerst_occ",       32'(occupancy), 32'd3);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data",  32'(out_data),  32'd0);
        chk("midrst_occ",       32'(occupancy), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("postrst_in_ready",  32'(in_ready),  32'd1);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        chk("postrst_idle",      32'(idle),      32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00E1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        #1;
        chk("resume_out_valid", 32'(out_valid), 32'd1);
        chk("resume_out_data",  32'(out_data),  32'h00E1);
        chk("resume_occ",       32'(occupancy), 32'd1);
        tick;
        #1;
        chk("resume_occ_end",   32'(occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
